nios_pio_ext: RTL
=================

// Module: nios_pio_ext
// PURPOSE
//  Parametrised Avalon-MM PIO for the Nios system: one zero-wait-state slave port.
//  Output register with atomic set/clear, optional per-bit blink driven by a prescaler,
//  and a synchronised input port with edge capture and a maskable interrupt.
//  Sits on the Nios data master alongside the LED/switch PIOs; drives board LEDs, reads keys.
// PARAMETERS
//  DATA_WIDTH     8   width of out_port, in_port and all data registers (1..32)
//  PRESCALE_WIDTH 24  width of blink prescaler reload register and counter (1..32)
//  EDGE_TYPE      0   edge capture: 0 rising, 1 falling, 2 any edge
//  RESET_VALUE    0   reset value of the output data register (DATA_WIDTH bits)
// PORTS
//  clk        in   1               system clock; single clock domain
//  reset_n    in   1               reset, synchronous, active-low
//  address    in   3               register select (word address)
//  chipselect in   1               slave select
//  write_n    in   1               write strobe, active-low; write when chipselect && !write_n
//  writedata  in   32              write data; only [DATA_WIDTH-1:0] used
//  readdata   out  32              read data, combinational from address, zero-extended
//  in_port    in   DATA_WIDTH      asynchronous external inputs (keys/switches)
//  out_port   out  DATA_WIDTH      external outputs (LEDs)
//  irq        out  1               interrupt, active-high level
// BEHAVIOUR
//  Register map (unused bits read 0; reads have no side effects; zero wait states):
//   0 DATA     RW  output data register
//   1 IN       RO  synchronised input value (sync2 stage); writes ignored
//   2 IRQMASK  RW  per-bit interrupt enable
//   3 EDGECAP  RW1C captured edges; write 1 clears bit, write 0 no effect
//   4 OUTSET   WO  data <= data | wd; reads 0
//   5 OUTCLR   WO  data <= data & ~wd; reads 0
//   6 BLINKEN  RW  per-bit blink enable
//   7 RELOAD   RW  prescaler reload (PRESCALE_WIDTH bits)
//  Reset (reset_n low at posedge clk): data=RESET_VALUE, irqmask=0, edgecap=0, blinken=0,
//   reload=0, cnt=0, phase=1, sync1/sync2/prev=0. Sync/prev regs are cleared, so an input
//   held high during reset sets EDGECAP (rising) 3 cycles after reset release.
//   Hence out_port=RESET_VALUE and irq=0 one cycle after reset is sampled.
//  Register writes take effect at the clock edge of the write cycle; readdata reflects
//   the new value in the next cycle.
//  Input path: sync1<=in_port; sync2<=sync1; prev<=sync2. Per bit:
//   rise = sync2&~prev, fall = ~sync2&prev, edge selected by EDGE_TYPE.
//   in_port change reaches IN after 2 clocks; EDGECAP bit sets on the 3rd edge.
//   EDGECAP bit: next = edge | (cap & ~clr), where clr is the RW1C write data.
//   Simultaneous edge and clear on the same bit: edge wins, bit stays 1.
//  irq = |(edgecap & irqmask); combinational from registers, no extra latency.
//  Blink prescaler:
//   - reload==0: cnt held 0, phase forced 1 (blinking bits show plain data).
//   - else each clock: cnt==0 -> cnt<=reload, phase<=~phase; otherwise cnt<=cnt-1.
//   - Phase toggles every reload+1 clocks.
//   - Write to RELOAD loads cnt with the new value in the same edge; phase unchanged.
//  out_port[i] = blinken[i] ? (data[i] & phase) : data[i]; combinational from registers.
//  DATA reads return the data register, not the blinked out_port.
//  Writes with chipselect low or write_n high are ignored. Address values are fully decoded.
// TESTING
//  1 Reset: hold reset_n=0 2 clks, RESET_VALUE=8'hA5 -> out_port=A5, irq=0,
//    readdata=0 at addrs 2,3,6,7.
//  2 Atomic ops: write DATA=8'h0F; OUTSET 8'h30; OUTCLR 8'h05 -> out_port=8'h3A,
//    read DATA=0000003A.
//  3 Edge capture (EDGE_TYPE=0): IRQMASK=01; pulse in_port[0] high 1 clk -> EDGECAP=01
//    3 clks later, irq=1. Write EDGECAP=01 -> irq=0 next clk. Falling edge -> no capture.
//  4 Clear/edge collision: time an EDGECAP write of 01 on the cycle bit0 edge is detected
//    -> EDGECAP stays 01, irq stays 1.
//  5 Blink: DATA=FF, BLINKEN=0F, RELOAD=3 -> out_port low nibble toggles 0F/00 every
//    4 clks, high nibble constant F. RELOAD=0 -> out_port=FF.
//  6 Reset mid-operation: during blink with EDGECAP=01, assert reset_n=0 for 1 clk
//    -> next cycle all regs at reset values, out_port=RESET_VALUE, irq=0.

Source files
------------

// File: rtl/nios_pio_ext.sv
// Avalon-MM PIO: output register with set/clear and blink,
// synchronised inputs with edge capture and maskable irq.
module nios_pio_ext #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 24,
  parameter int unsigned EDGE_TYPE      = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PRESCALE_WIDTH;

  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] irqmask_q, irqmask_d;
  logic [DW-1:0] edgecap_q, edgecap_d;
  logic [DW-1:0] blinken_q, blinken_d;
  logic [PW-1:0] reload_q, reload_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [DW-1:0] sync1_q, sync2_q, prev_q;

  logic          wr;
  logic [DW-1:0] wd;
  logic [PW-1:0] wd_reload;
  logic [DW-1:0] clr;
  logic [DW-1:0] edg;
  logic          unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DW-1:0];
  assign wd_reload = writedata[PW-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    edg = sync2_q & ~prev_q;
    if (EDGE_TYPE == 1)
      edg = ~sync2_q & prev_q;
    else if (EDGE_TYPE == 2)
      edg = sync2_q ^ prev_q;
  end

  assign clr = (wr && address == 3'd3) ? wd : '0;

  always_comb begin
    data_d    = data_q;
    irqmask_d = irqmask_q;
    blinken_d = blinken_q;
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    edgecap_d = edg | (edgecap_q & ~clr);

    // Prescaler free-runs; a RELOAD write below overrides cnt only.
    if (reload_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = reload_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - 1'b1;
    end

    if (wr) begin
      case (address)
        3'd0: data_d    = wd;
        3'd2: irqmask_d = wd;
        3'd4: data_d    = data_q | wd;
        3'd5: data_d    = data_q & ~wd;
        3'd6: blinken_d = wd;
        3'd7: begin
          reload_d = wd_reload;
          cnt_d    = wd_reload;
          phase_d  = phase_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q    <= RESET_VALUE;
      irqmask_q <= '0;
      edgecap_q <= '0;
      blinken_q <= '0;
      reload_q  <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
    end else begin
      data_q    <= data_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      blinken_q <= blinken_d;
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(data_q);
      3'd1: readdata = 32'(sync2_q);
      3'd2: readdata = 32'(irqmask_q);
      3'd3: readdata = 32'(edgecap_q);
      3'd6: readdata = 32'(blinken_q);
      3'd7: readdata = 32'(reload_q);
      default: readdata = '0;
    endcase
  end

  assign out_port = (data_q & ~blinken_q)
                  | (data_q & blinken_q & {DW{phase_q}});
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
